// File: rtl/prt_frame_transmitter.sv
// Frame transmitter: streams a stored frame out of a slot of the frame buffer
// through a 2-deep valid/ready output buffer, then returns the slot.
//
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   tx_req/tx_slot_id/tx_len -> tx_ack/tx_err : request handshake (IDLE only)
//   mem_rd_en/slot/addr -> mem_rd_data        : buffer read, data 1 cycle later
//   frame_out_valid/data/last <- frame_out_ready : byte stream to the sink
//   slot_free_valid/slot_free_id              : slot release pulse
//   busy                                      : high outside IDLE
module prt_frame_transmitter #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 11,
    parameter int NUM_ENTRIES = 10,
    parameter int FRAME_SIZE  = 1518,
    parameter int SLOT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_req,
    input  logic [SLOT_W-1:0]     tx_slot_id,
    input  logic [ADDR_WIDTH-1:0] tx_len,
    output logic                  tx_ack,
    output logic                  tx_err,
    output logic                  mem_rd_en,
    output logic [SLOT_W-1:0]     mem_rd_slot,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  frame_out_valid,
    output logic [DATA_WIDTH-1:0] frame_data_out,
    output logic                  frame_out_last,
    input  logic                  frame_out_ready,
    output logic                  slot_free_valid,
    output logic [SLOT_W-1:0]     slot_free_id,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_RELEASE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [ADDR_WIDTH-1:0]   len_q, len_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    // read issued last cycle; its data is on mem_rd_data this cycle
    logic                    pend_q, pend_d;
    logic                    pend_last_q, pend_last_d;
    // output buffer: entry 0 is the head presented to the sink
    logic [1:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   b0_data_q, b0_data_d;
    logic [DATA_WIDTH-1:0]   b1_data_q, b1_data_d;
    logic                    b0_last_q, b0_last_d;
    logic                    b1_last_q, b1_last_d;

    logic                    ack_c;
    logic                    err_c;
    logic                    rd_c;
    logic                    pop;
    logic                    room;
    logic                    rd_is_last;
    logic                    req_bad;

    assign pop        = (cnt_q != 2'd0) && frame_out_ready;
    // buffered + in-flight bytes; at most 3 so 2 bits suffice
    assign room       = (cnt_q + {1'b0, pend_q}) < 2'd2;
    assign rd_is_last = (addr_q == (len_q - ADDR_ONE));
    assign req_bad    = (32'(tx_slot_id) >= 32'(NUM_ENTRIES))
                     || (tx_len == '0)
                     || (32'(tx_len) > 32'(FRAME_SIZE));

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        len_d       = len_q;
        addr_d      = addr_q;
        ack_c       = 1'b0;
        err_c       = 1'b0;
        rd_c        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (tx_req) begin
                    if (req_bad) begin
                        err_c = 1'b1;
                    end else begin
                        ack_c   = 1'b1;
                        slot_d  = tx_slot_id;
                        len_d   = tx_len;
                        addr_d  = '0;
                        state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (room || pop) begin
                    rd_c = 1'b1;
                    // hold the address at len-1 so it never wraps
                    if (rd_is_last) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && b0_last_q) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pend_d      = rd_c;
    assign pend_last_d = rd_c && rd_is_last;

    always_comb begin
        cnt_d     = cnt_q;
        b0_data_d = b0_data_q;
        b0_last_d = b0_last_q;
        b1_data_d = b1_data_q;
        b1_last_d = b1_last_q;
        if (pop) begin
            b0_data_d = b1_data_q;
            b0_last_d = b1_last_q;
            cnt_d     = cnt_q - 2'd1;
        end
        if (pend_q) begin
            if (cnt_d == 2'd0) begin
                b0_data_d = mem_rd_data;
                b0_last_d = pend_last_q;
            end else begin
                b1_data_d = mem_rd_data;
                b1_last_d = pend_last_q;
            end
            cnt_d = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            slot_q      <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            cnt_q       <= 2'd0;
            b0_data_q   <= '0;
            b0_last_q   <= 1'b0;
            b1_data_q   <= '0;
            b1_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            cnt_q       <= cnt_d;
            b0_data_q   <= b0_data_d;
            b0_last_q   <= b0_last_d;
            b1_data_q   <= b1_data_d;
            b1_last_q   <= b1_last_d;
        end
    end

    // the handshake is combinational from tx_req, so mask it during reset
    assign tx_ack          = ack_c && rst;
    assign tx_err          = err_c && rst;
    assign mem_rd_en       = rd_c;
    assign mem_rd_slot     = slot_q;
    assign mem_rd_addr     = addr_q;
    assign frame_out_valid = (cnt_q != 2'd0);
    assign frame_data_out  = b0_data_q;
    assign frame_out_last  = (cnt_q != 2'd0) && b0_last_q;
    assign slot_free_valid = (state_q == S_RELEASE);
    assign slot_free_id    = slot_q;
    assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_prt_frame_transmitter.sv
// Self-checking bench for prt_frame_transmitter: a frame-level model
// (expected byte queue, read-address cursor, release timing) checked every cycle.
module tb_prt_frame_transmitter;

    localparam int DW = 8;
    localparam int AW = 11;
    localparam int NE = 10;
    localparam int FS = 1518;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tx_req = 1'b0;
    logic [SW-1:0] tx_slot_id = '0;
    logic [AW-1:0] tx_len = '0;
    logic          tx_ack;
    logic          tx_err;
    logic          mem_rd_en;
    logic [SW-1:0] mem_rd_slot;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          frame_out_valid;
    logic [DW-1:0] frame_data_out;
    logic          frame_out_last;
    logic          frame_out_ready = 1'b1;
    logic          slot_free_valid;
    logic [SW-1:0] slot_free_id;
    logic          busy;

    prt_frame_transmitter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_ENTRIES(NE),
        .FRAME_SIZE (FS),
        .SLOT_W     (SW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .tx_req         (tx_req),
        .tx_slot_id     (tx_slot_id),
        .tx_len         (tx_len),
        .tx_ack         (tx_ack),
        .tx_err         (tx_err),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_slot    (mem_rd_slot),
        .mem_rd_addr    (mem_rd_addr),
        .mem_rd_data    (mem_rd_data),
        .frame_out_valid(frame_out_valid),
        .frame_data_out (frame_data_out),
        .frame_out_last (frame_out_last),
        .frame_out_ready(frame_out_ready),
        .slot_free_valid(slot_free_valid),
        .slot_free_id   (slot_free_id),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [16][2048];

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_slot][mem_rd_addr];
    end

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // frame-level model state
    logic [8:0]    exp_q[$];
    logic [7:0]    got_q[$];
    int            rd_next = 0;
    int            rd_len = 0;
    bit            rd_ok = 0;
    logic [SW-1:0] cur_slot = '0;
    bit            free_due = 0;
    logic [SW-1:0] free_slot = '0;
    bit            in_frame = 0;
    bit            held = 0;
    logic [8:0]    held_val = '0;
    int            outst = 0;
    int            first_rd = -1;
    int            first_vld = -1;
    int            free_cyc = -1;
    int            n_free = 0;
    int            n_rd = 0;
    int            n_xfer_frame = 0;
    int            last_frame_len = 0;
    int            rmode = 0;

    always @(posedge clk) begin
        #1;
        case (rmode)
            0: frame_out_ready = 1'b1;
            1: frame_out_ready = ~frame_out_ready;
            default: frame_out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst) begin
            chk("reset_outputs",
                64'({tx_ack, tx_err, mem_rd_en, mem_rd_slot, mem_rd_addr,
                     frame_out_valid, frame_data_out, frame_out_last,
                     slot_free_valid, slot_free_id, busy}), 64'd0);
            exp_q.delete();
            rd_ok = 0;
            free_due = 0;
            held = 0;
            outst = 0;
            in_frame = 0;
        end else begin
            chk("busy", 64'(busy), 64'(in_frame));
            if (in_frame) chk("req_ignored", 64'({tx_ack, tx_err}), 64'd0);
            chk("slot_free_valid", 64'(slot_free_valid), 64'(free_due));
            if (free_due && slot_free_valid)
                chk("slot_free_id", 64'(slot_free_id), 64'(free_slot));
            if (slot_free_valid) begin
                free_cyc = cyc;
                n_free++;
            end
            if (free_due) in_frame = 0;
            free_due = 0;
            if (mem_rd_en) begin
                chk("rd_allowed", 64'(rd_ok), 64'd1);
                chk("rd_addr", 64'(mem_rd_addr), 64'(rd_next));
                chk("rd_slot", 64'(mem_rd_slot), 64'(cur_slot));
                if (first_rd < 0) first_rd = cyc;
                rd_next++;
                n_rd++;
                outst++;
                if (rd_next >= rd_len) rd_ok = 0;
            end
            if (held) begin
                chk("hold_valid", 64'(frame_out_valid), 64'd1);
                chk("hold_data", 64'({frame_out_last, frame_data_out}),
                    64'(held_val));
            end
            if (frame_out_valid && first_vld < 0) first_vld = cyc;
            if (frame_out_valid && frame_out_ready) begin
                outst--;
                n_xfer_frame++;
                got_q.push_back(frame_data_out);
                if (exp_q.size() == 0) begin
                    chk("spurious_byte", 64'(frame_out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 64'(frame_data_out), 64'(e[7:0]));
                    chk("out_last", 64'(frame_out_last), 64'(e[8]));
                    if (e[8]) begin
                        free_due = 1;
                        free_slot = cur_slot;
                        last_frame_len = n_xfer_frame;
                    end
                end
            end
            chk("lookahead", 64'(outst <= 2), 64'd1);
            held = frame_out_valid && !frame_out_ready;
            held_val = {frame_out_last, frame_data_out};
        end
    end

    task automatic do_req(input int slot, input int len, input int hold,
                          output int acyc);
        bit ok;
        bit done;
        ok = (slot < NE) && (len > 0) && (len <= FS);
        done = 0;
        acyc = -1;
        @(posedge clk);
        #1;
        tx_req = 1'b1;
        tx_slot_id = SW'(slot);
        tx_len = AW'(len);
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            if (tx_ack || tx_err) begin
                done = 1;
                acyc = cyc;
                chk("tx_ack", 64'(tx_ack), 64'(ok));
                chk("tx_err", 64'(tx_err), 64'(!ok));
                if (ok) begin
                    for (int j = 0; j < len; j++)
                        exp_q.push_back({(j == len - 1), mem[slot][j]});
                    cur_slot = SW'(slot);
                    rd_next = 0;
                    rd_len = len;
                    rd_ok = 1;
                    first_rd = -1;
                    first_vld = -1;
                    n_xfer_frame = 0;
                    got_q.delete();
                end
            end
        end
        if (!done) chk("req_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        if (ok && done) in_frame = 1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
        end
        tx_req = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (in_frame && i < 6000) begin
            @(negedge clk);
            i++;
        end
        if (in_frame) begin
            chk("frame_timeout", 64'(in_frame), 64'd0);
            in_frame = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_lit(input string name, input logic [7:0] l0,
                           input logic [7:0] l1, input logic [7:0] l2,
                           input logic [7:0] l3, input logic [7:0] l4);
        logic [7:0] lit [5];
        lit = '{l0, l1, l2, l3, l4};
        chk({name, "_count"}, 64'(got_q.size()), 64'd5);
        for (int i = 0; i < 5 && i < got_q.size(); i++)
            chk({name, "_byte"}, 64'(got_q[i]), 64'(lit[i]));
    endtask

    initial begin
        int a;
        int a2;
        int nf;
        int nr;
        int sl;
        int ln;
        int k;

        for (int s = 0; s < 16; s++)
            for (int i = 0; i < 2048; i++)
                mem[s][i] = 8'($urandom);
        mem[3][0] = 8'hAA;
        mem[3][1] = 8'hBB;
        mem[3][2] = 8'hCC;
        mem[3][3] = 8'hDD;
        mem[3][4] = 8'hEE;
        mem[0][0] = 8'h5A;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // slot 3, len 5, ready high: fixed latency
        rmode = 0;
        do_req(3, 5, 0, a);
        wait_done();
        chk("s1_first_rd", 64'(first_rd), 64'(a + 1));
        chk("s1_first_vld", 64'(first_vld), 64'(a + 3));
        chk("s1_free_cyc", 64'(free_cyc), 64'(a + 8));
        chk_lit("s1", 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE);

        // same frame with ready toggling
        rmode = 1;
        nf = n_free;
        do_req(3, 5, 0, a);
        wait_done();
        chk_lit("s2", 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE);
        chk("s2_free_pulses", 64'(n_free), 64'(nf + 1));
        rmode = 0;

        // rejected requests
        nf = n_free;
        nr = n_rd;
        do_req(3, 0, 0, a);
        @(negedge clk);
        chk("s3_err_single_len0", 64'(tx_err), 64'd0);
        do_req(3, 1519, 0, a);
        @(negedge clk);
        chk("s3_err_single_len1519", 64'(tx_err), 64'd0);
        do_req(10, 5, 0, a);
        @(negedge clk);
        chk("s3_err_single_slot10", 64'(tx_err), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("s3_no_free", 64'(n_free), 64'(nf));
        chk("s3_no_reads", 64'(n_rd), 64'(nr));

        // 1-byte frame from slot 0
        do_req(0, 1, 0, a);
        wait_done();
        chk("s4_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) chk("s4_byte", 64'(got_q[0]), 64'h5A);
        chk("s4_first_vld", 64'(first_vld), 64'(a + 3));
        chk("s4_free_cyc", 64'(free_cyc), 64'(a + 4));
        chk("s4_len", 64'(last_frame_len), 64'd1);

        // reset after the second byte of a 5-byte frame
        nf = n_free;
        do_req(4, 5, 0, a);
        k = 0;
        while (n_xfer_frame < 2 && k < 100) begin
            @(posedge clk);
            k++;
        end
        if (n_xfer_frame < 2) chk("s5_wait", 64'(n_xfer_frame), 64'd2);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        tx_req = 1'b1;
        tx_slot_id = 4'd4;
        tx_len = 11'd5;
        repeat (3) @(posedge clk);
        #1;
        tx_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("s5_no_free", 64'(n_free), 64'(nf));
        do_req(4, 5, 0, a);
        wait_done();
        chk("s5_first_rd", 64'(first_rd), 64'(a + 1));
        chk_lit("s5", mem[4][0], mem[4][1], mem[4][2], mem[4][3], mem[4][4]);

        // max-length frame, then a request held across its end
        do_req(7, FS, 0, a);
        k = 0;
        while (n_xfer_frame < FS - 10 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        do_req(2, 20, 0, a2);
        chk("s6_len", 64'(last_frame_len), 64'(FS));
        chk("s6_b2b_ack", 64'(a2), 64'(free_cyc + 1));
        wait_done();

        // randomized requests and ready patterns
        for (int t = 0; t < 40; t++) begin
            rmode = $urandom_range(0, 2);
            sl = $urandom_range(0, 15);
            if (sl >= NE && $urandom_range(0, 1) == 1) sl = sl - 8;
            case ($urandom_range(0, 9))
                0: ln = 0;
                1: ln = $urandom_range(FS + 1, 2047);
                2: ln = 1;
                3: ln = $urandom_range(100, 300);
                default: ln = $urandom_range(2, 40);
            endcase
            do_req(sl, ln, (ln >= 8) ? $urandom_range(0, 2) : 0, a);
            wait_done();
        end

        rmode = 0;
        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prt_frame_transmitter.md
PRT_FRAME_TRANSMITTER -- requirements
Module: prt_frame_transmitter

Interface
REQ-001 SHALL take parameter DATA_WIDTH, default 8: byte-lane width of stored and transmitted frame data.
REQ-002 SHALL take parameter ADDR_WIDTH, default 11: byte-index width within one slot.
REQ-003 SHALL take parameter NUM_ENTRIES, default 10: number of packet reference table slots.
REQ-004 SHALL take parameter FRAME_SIZE, default 1518: maximum frame length in bytes.
REQ-005 SHALL take parameter SLOT_W, default 4: slot-id width, with 2**SLOT_W >= NUM_ENTRIES.
REQ-006 SHALL have port clk, input, 1: the single clock; one clock.
REQ-007 SHALL have port rst, input, 1: reset; reset is asynchronous and active-low.
REQ-008 SHALL have port tx_req, input, 1: transmit request; the requester holds it until tx_ack or tx_err.
REQ-009 SHALL have port tx_slot_id, input, SLOT_W: slot to transmit; sampled with tx_req.
REQ-010 SHALL have port tx_len, input, ADDR_WIDTH: frame length in bytes; sampled with tx_req.
REQ-011 SHALL have port tx_ack, output, 1: one-cycle pulse when a valid request is accepted.
REQ-012 SHALL have port tx_err, output, 1: one-cycle pulse when a request is rejected.
REQ-013 SHALL have port mem_rd_en, output, 1: frame-buffer read strobe.
REQ-014 SHALL have port mem_rd_slot, output, SLOT_W: slot being read.
REQ-015 SHALL have port mem_rd_addr, output, ADDR_WIDTH: byte index being read.
REQ-016 SHALL have port mem_rd_data, input, DATA_WIDTH: read data, valid exactly 1 cycle after mem_rd_en.
REQ-017 SHALL have port frame_out_valid, output, 1: output byte valid.
REQ-018 SHALL have port frame_data_out, output, DATA_WIDTH: output byte.
REQ-019 SHALL have port frame_out_last, output, 1: marks the final byte of a frame; qualified by frame_out_valid.
REQ-020 SHALL have port frame_out_ready, input, 1: sink ready; a byte transfers when valid and ready are both high.
REQ-021 SHALL have port slot_free_valid, output, 1: one-cycle pulse returning a slot to the table.
REQ-022 SHALL have port slot_free_id, output, SLOT_W: slot released; qualified by slot_free_valid.
REQ-023 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-024 SHALL implement four states: IDLE, STREAM, DRAIN and RELEASE.
REQ-025 In IDLE with tx_req high, the block SHALL do one of the following:
- Pulse tx_err and stay in IDLE if tx_slot_id >= NUM_ENTRIES.
- Pulse tx_err and stay in IDLE if tx_len == 0 or tx_len > FRAME_SIZE.
- Otherwise, pulse tx_ack, latch slot and length, and enter STREAM.
REQ-026 tx_req SHALL be ignored outside IDLE, with no ack and no err.
REQ-027 In STREAM, reads SHALL be issued at byte indices 0..len-1, in order and with no gaps.
- A read SHALL be issued only while (bytes buffered + reads in flight) < 2, or when a byte transfers in the same cycle.
REQ-028 The block SHALL hold a 2-entry output buffer, so that no byte is lost or duplicated under any frame_out_ready pattern.
REQ-029 frame_data_out, frame_out_valid and frame_out_last SHALL be stable while frame_out_valid is high and frame_out_ready is low.
REQ-030 Latency with frame_out_ready held high:
- Cycle N: tx_ack.
- Cycle N+1: mem_rd_en with address 0.
- Cycle N+3: first frame_out_valid.
- Thereafter, one byte per cycle.
REQ-031 The block SHALL enter DRAIN once the read of byte len-1 is issued, and SHALL issue no further reads.
REQ-032 frame_out_last SHALL be high only with byte len-1; a 1-byte frame SHALL assert valid and last together.
REQ-033 After the last byte transfers, the block SHALL enter RELEASE and pulse slot_free_valid with the latched slot for exactly one cycle, then return to IDLE.
REQ-034 The earliest next tx_ack SHALL be the cycle after RELEASE.
REQ-035 mem_rd_addr SHALL never exceed len-1; its internal counter SHALL be ADDR_WIDTH bits and SHALL not wrap.
REQ-036 A rejected request SHALL NOT produce mem_rd_en or slot_free_valid.

Reset
REQ-037 While rst is low, the block SHALL return to IDLE and clear both the output buffer and all counters.
REQ-038 While rst is low, every output SHALL be 0.
REQ-039 Reset mid-frame SHALL abort the frame with no frame_out_last and no slot_free_valid for that slot.
REQ-040 The first tx_req SHALL be accepted no earlier than the first rising clk edge after rst deasserts.

Verification
REQ-041 Scenario: slot 3, len 5, memory holds AA BB CC DD EE, ready high -> tx_ack at N, bytes AA..EE on N+3..N+7, last with EE, slot_free_valid/id=3 at N+8.
REQ-042 Scenario: same frame, ready toggled 1-0-1-0 -> exactly AA BB CC DD EE delivered, data held while stalled, one slot_free pulse.
REQ-043 Scenario: tx_len=0, tx_len=1519 or tx_slot_id=10 -> single tx_err pulse each, no mem_rd_en, no slot_free_valid.
REQ-044 Scenario: len 1, slot 0 -> one byte with valid and last together, then slot_free_id=0.
REQ-045 Scenario: rst low after the 2nd byte of a len-5 frame -> all outputs 0, no slot_free_valid; a new len-5 request is served from byte 0.
REQ-046 Scenario: len 1518 with ready high, then a back-to-back request -> 1518 bytes, last only on the final byte, second tx_ack one cycle after RELEASE.
